// File: rtl/serial_sub_4b.sv
// rtl/serial_sub_4b.sv - bit-serial ripple-borrow subtractor, D = A - B - Bin, LSB first
// Optional overflow flag output V is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_SUB_OVF_EN
    output logic             V,
`endif
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;

    logic             diff_d;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;
    logic             last_bit;

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        diff_d   = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
        borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
        res_d    = {diff_d, res_sh_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic v_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            v_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh_q   <= A;
                        b_sh_q   <= B;
                        res_sh_q <= '0;
                        borrow_q <= Bin;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q  <= A[WIDTH-1];
                        b_msb_q  <= B[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    // Result registers change only here, so D is held through IDLE and RUN.
                    if (last_bit) begin
                        d_q     <= res_d;
                        bout_q  <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        v_q     <= (a_msb_q ^ b_msb_q) & (diff_d ^ a_msb_q);
`endif
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign D     = d_q;
    assign Bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign V     = v_q;
`endif

endmodule

// File: tb/tb_serial_sub_4b.sv
// tb/tb_serial_sub_4b.sv - directed self-checking bench for serial_sub_4b
// Checks V as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_4b;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         V;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] prev_d = '0;
    logic         prev_b = 1'b0;

    serial_sub_4b #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
`ifdef SERIAL_SUB_OVF_EN
        .V     (V),
`endif
        .D     (D),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ready, busy, done, D, Bout} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got rdy/bsy/dn/D/Bout=%b%b%b/%h/%b want 100/0/0",
                     ready, busy, done, D, Bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (V !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_v: got %b want 0", V);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        prev_d = '0;
        prev_b = 1'b0;
    endtask

    // Runs one operation starting at a negedge; returns at the negedge where ready is back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0]   full;
        logic [W-1:0] ed;
        logic         eb;
        int           guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_ready: got ready=%b want 1 within 20 cycles", ready);
        end
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        ed = full[W-1:0];
        eb = full[W];
        A = a;
        B = b;
        Bin = bin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = ~a;
        B = ~b;
        Bin = ~bin;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, ready} !== 3'b100 || D !== prev_d || Bout !== prev_b) begin
                miscompares++;
                $display("FAIL run_cycle%0d a=%h b=%h bin=%b: got bsy/dn/rdy=%b%b%b D=%h Bout=%b want 100 D=%h Bout=%b",
                         i, a, b, bin, busy, done, ready, D, Bout, prev_d, prev_b);
            end
        end
        @(negedge clk);
        vectors++;
        if ({busy, done, ready} !== 3'b010 || D !== ed || Bout !== eb) begin
            miscompares++;
            $display("FAIL result a=%h b=%h bin=%b: got bsy/dn/rdy=%b%b%b D=%h Bout=%b want 010 D=%h Bout=%b",
                     a, b, bin, busy, done, ready, D, Bout, ed, eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (V !== ((a[W-1] ^ b[W-1]) & (ed[W-1] ^ a[W-1]))) begin
            miscompares++;
            $display("FAIL overflow a=%h b=%h: got V=%b want %b",
                     a, b, V, (a[W-1] ^ b[W-1]) & (ed[W-1] ^ a[W-1]));
        end
`endif
        @(negedge clk);
        vectors++;
        if ({busy, done, ready} !== 3'b001 || D !== ed || Bout !== eb) begin
            miscompares++;
            $display("FAIL after_done a=%h b=%h: got bsy/dn/rdy=%b%b%b D=%h Bout=%b want 001 D=%h Bout=%b",
                     a, b, busy, done, ready, D, Bout, ed, eb);
        end
        prev_d = ed;
        prev_b = eb;
    endtask

    task automatic test_basic();
        run_op(4'd9, 4'd3, 1'b0);
        run_op(4'd3, 4'd9, 1'b0);
        vectors++;
        if (D !== 4'hA || Bout !== 1'b1) begin
            miscompares++;
            $display("FAIL borrow_3_9: got D=%h Bout=%b want a/1", D, Bout);
        end
        run_op(4'd0, 4'd0, 1'b1);
        vectors++;
        if (D !== 4'hF || Bout !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_minus_bin: got D=%h Bout=%b want f/1", D, Bout);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 512; i++) begin
            run_op(i[3:0], i[7:4], i[8]);
        end
    endtask

    task automatic test_hold_start();
        A = 4'd5;
        B = 4'd2;
        Bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        A = 4'd7;
        B = 4'd1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, ready} !== 3'b100) begin
                miscompares++;
                $display("FAIL hold_run%0d: got bsy/dn/rdy=%b%b%b want 100", i, busy, done, ready);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || D !== 4'd3 || Bout !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_first: got done=%b D=%h Bout=%b want 1 3 0", done, D, Bout);
        end
        @(negedge clk);
        vectors++;
        if ({busy, done, ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL hold_idle: got bsy/dn/rdy=%b%b%b want 001", busy, done, ready);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1 || D !== 4'd3) begin
                miscompares++;
                $display("FAIL hold_second_run%0d: got busy=%b D=%h want 1 3", i, busy, D);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || D !== 4'd6 || Bout !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_second: got done=%b D=%h Bout=%b want 1 6 0", done, D, Bout);
        end
        @(negedge clk);
        prev_d = 4'd6;
        prev_b = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        A = 4'd9;
        B = 4'd3;
        Bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ready, busy, done, D, Bout} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got rdy/bsy/dn/D/Bout=%b%b%b/%h/%b want 100/0/0",
                     ready, busy, done, D, Bout);
        end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done cycles want 0", seen_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        prev_d = '0;
        prev_b = 1'b0;
        run_op(4'd9, 4'd3, 1'b0);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_overflow();
        run_op(4'b0111, 4'b1000, 1'b0);
        vectors++;
        if (D !== 4'hF || Bout !== 1'b1 || V !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got D=%h Bout=%b V=%b want f 1 1", D, Bout, V);
        end
        run_op(4'd5, 4'd2, 1'b0);
        vectors++;
        if (V !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got V=%b want 0", V);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold_start();
        test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
        test_overflow();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_sub_4b.md
Name: serial_sub_4b

Overview:
- Bit-serial ripple-borrow subtractor, the inverse operation to the team's 4-bit ripple-carry adder.
- Computes D = A - B - Bin, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Used where area matters more than latency.
- Operands are latched on a start handshake. The result is returned with a one-cycle done pulse and then held.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while ready=1.
- A  input  WIDTH  minuend; latched when start is accepted.
- B  input  WIDTH  subtrahend; latched when start is accepted.
- Bin  input  1  borrow-in; latched when start is accepted.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- D  output  WIDTH  difference, held until the next accepted start.
- Bout  output  1  borrow-out of the MSB, held with D.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, D=0, Bout=0, internal shift registers, borrow flop and bit counter cleared.
- States:
  - IDLE -> RUN when start=1.
  - RUN -> DONE when the final bit has been processed.
  - DONE -> IDLE unconditionally after one cycle.
- Accept (IDLE, start=1 at edge k):
  - latch A and B into shift registers, borrow flop <= Bin, counter <= 0, state <= RUN.
- RUN, each edge:
  - a = A_sh[0], b = B_sh[0], br = borrow flop.
  - diff bit = a^b^br.
  - next borrow = (~a & b) | (~(a^b) & br).
  - Shift diff bit into the MSB of the result register; shift A_sh and B_sh right; counter increments.
  - After edge k+WIDTH the counter equals WIDTH and state <= DONE.
- DONE cycle (between edges k+WIDTH and k+WIDTH+1):
  - done=1.
  - D = the full difference, LSB aligned.
  - Bout = final borrow.
- Latency: done is high exactly WIDTH cycles after the accept edge. Throughput is one operation per WIDTH+2 cycles.
- D and Bout update only on the transition into DONE. They hold through IDLE and through the next RUN until the next DONE.
- Arithmetic: result equals (A - B - Bin) mod 2^WIDTH. Bout=1 iff A < B + Bin, unsigned.
- start while busy or in DONE: ignored, with no effect on state or latched operands.
- A, B and Bin changes after accept: no effect.
- Reset asserted mid-RUN: aborts immediately. No done pulse is produced, and outputs go to their reset values.
- ready, busy and done are mutually exclusive and registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- With the macro defined:
  - extra port V, output, 1 bit: two's-complement overflow flag.
  - V = (A[W-1]^B[W-1]) & (D[W-1]^A[W-1]), using the latched operand signs.
  - Registered alongside D: reset 0, updated only on entry to DONE, held with D.
- Without the macro: port V and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then A=4'd9, B=4'd3, Bin=0, start pulse -> busy for 4 cycles; done pulse 4 cycles after accept; D=4'd6, Bout=0; ready returns the next cycle.
- A=4'd3, B=4'd9, Bin=0 -> D=4'hA, Bout=1. Then A=0, B=0, Bin=1 -> D=4'hF, Bout=1.
- Exhaustive 256x2 loop of A, B and Bin with back-to-back starts issued the cycle ready rises -> every D and Bout matches (A-B-Bin) mod 16 and its borrow; D is stable between done pulses.
- Accept A=5, B=2; hold start=1 with different operands throughout RUN and DONE -> only one operation is accepted; result D=3. The second operation starts only when start is seen in IDLE.
- Drop rst_n at cycle 2 of RUN -> outputs reset asynchronously, no done pulse; a new start after release computes correctly.
- With SERIAL_SUB_OVF_EN: A=4'b0111, B=4'b1000, Bin=0 -> D=4'hF, Bout=1, V=1. A=4'd5, B=4'd2 -> V=0.
